seq_onehot_decoder: RTL
=======================

Name: seq_onehot_decoder

Overview:
Parametrised, registered successor to the team's fixed 3-to-8 one-hot decoder. Decodes an SEL_W-bit index into an OUT_W-bit one-hot vector. Three modes: latched decode, single-cycle pulse, and auto-scan, which steps the active output with a programmable dwell. Drives register-file write enables, sprite/channel strobes and round-robin polling selects in the game datapath.

Parameters:
SEL_W, 3, width of index input.
OUT_W, 8, number of one-hot outputs; legal range 2..2**SEL_W.
HOLD_W, 4, width of scan dwell counter.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
en  in  1  block enable; low forces IDLE at next edge
mode  in  2  00 LATCH, 01 PULSE, 10 SCAN, 11 reserved
load  in  1  start/update strobe; sampled only when en=1
sel  in  SEL_W  index to decode
hold  in  HOLD_W  scan dwell; each index stays active hold+1 cycles
out  out  OUT_W  registered one-hot (or all-zero) select vector
busy  out  1  high while SCAN is running
wrap  out  1  one-cycle pulse when scan steps OUT_W-1 -> 0
err  out  1  one-cycle pulse when a load carries sel >= OUT_W

Behaviour:
- Reset (synchronous, active-high): out=0, busy=0, wrap=0, err=0, state=IDLE, index=0, dwell=0. Reset dominates en and load in the same cycle.
- All outputs are registered. A load at edge N is visible on out after edge N (1-cycle latency).
- States: IDLE, HOLD (latched), PULSE, SCAN.
- Any state with en=0 -> IDLE at the next edge; out=0, busy=0.
- IDLE/HOLD/PULSE with en=1 and load=1:
  - mode 00 -> HOLD, out=onehot(sel).
  - mode 01 -> PULSE, out=onehot(sel).
  - mode 10 -> SCAN, index=sel, dwell=hold, out=onehot(sel), busy=1.
  - mode 11 -> IDLE, out=0.
- HOLD without load: out unchanged. Changing mode or sel without load has no effect.
- PULSE: next edge -> IDLE, out=0. A back-to-back load in PULSE re-enters PULSE with the new sel, so out is continuous across consecutive loads.
- SCAN without load:
  - dwell != 0: dwell decrements.
  - dwell == 0: index advances, dwell reloads from the current hold input, out=onehot(new index).
  - index OUT_W-1 advances to 0 and wrap=1 on that same edge.
- SCAN with load: restarts per the load rules above, using the current mode; load beats step.
- Out-of-range load (sel >= OUT_W, any mode except 11): err=1 for one cycle, state -> IDLE, out=0.
- Invariant: out is one-hot or all-zero at every edge; never multi-hot.
- hold=0 in SCAN: index advances every cycle.
- OUT_W < 2**SEL_W: the scan wrap point is OUT_W-1, not 2**SEL_W-1.

Decomposition:
- Shared package/include holds:
  - mode encodings MODE_LATCH=2'b00, MODE_PULSE=2'b01, MODE_SCAN=2'b10, MODE_RSVD=2'b11;
  - state encodings ST_IDLE, ST_HOLD, ST_PULSE, ST_SCAN.
- One sub-module: onehot_decode, a combinational, parametrised SEL_W -> OUT_W decoder with an in-range flag.
- The top module contains the state register, index/dwell counters and output registers.

Test Plan:
- Reset for 2 cycles with load=1, sel=5 asserted -> out=0, busy=0, wrap=0, err=0 throughout. First load after reset (mode 00, sel=5) -> out=8'h20 one cycle later, held for 10 idle cycles.
- PULSE, sel=2, load high for 1 cycle -> out=8'h04 for exactly one cycle, then 0. Load held 3 cycles with sel=1,2,3 -> out=02,04,08, then 0.
- SCAN, sel=6, hold=1 -> out=40,40,80,80,01,01,02... busy=1 throughout; wrap=1 only on the cycle out first becomes 01.
- SCAN, hold=0, OUT_W=6 build -> out cycles 01..20 each cycle; wrap at 20->01. Drop en mid-scan -> out=0, busy=0 the next cycle.
- Out-of-range load on the OUT_W=6 build: sel=7 while HOLD with out=04 -> err pulses once, out=0, state IDLE. Next in-range load works normally.
- mode=11 with load -> out=0, err=0. Reset asserted mid-SCAN -> all outputs 0 at the next edge; scan does not resume after reset release.

Source files
------------

// File: rtl/seq_onehot_decoder_pkg.sv
// Shared encodings for the sequenced one-hot decoder: operating modes and
// controller states.
package seq_onehot_decoder_pkg;

    typedef enum logic [1:0] {
        MODE_LATCH = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_PULSE = 2'b10,
        ST_SCAN  = 2'b11
    } state_e;

endpackage

// File: rtl/seq_onehot_decoder_onehot_decode.sv
// Combinational SEL_W -> OUT_W one-hot decoder. An index at or beyond OUT_W
// yields all-zero and drops in_range.
module onehot_decode #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot,
    output logic             in_range
);

    localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(OUT_W);

    // Decode the index; only the bit matching sel is set.
    always_comb begin
        onehot   = '0;
        in_range = ({1'b0, sel} < LIMIT);
        for (int i = 0; i < OUT_W; i++) begin
            if (sel == SEL_W'(i)) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered one-hot select generator with latched, single-cycle pulse and
// auto-scan modes; the scan dwells hold+1 cycles on each index.
module seq_onehot_decoder
    import seq_onehot_decoder_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int OUT_W  = 8,
    parameter int HOLD_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [SEL_W-1:0]  sel,
    input  logic [HOLD_W-1:0] hold,
    output logic [OUT_W-1:0]  out,
    output logic              busy,
    output logic              wrap,
    output logic              err
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    state_e             state_r;
    logic [SEL_W-1:0]   index_r;
    logic [HOLD_W-1:0]  dwell_r;
    logic [OUT_W-1:0]   out_r;
    logic               busy_r;
    logic               wrap_r;
    logic               err_r;

    mode_e              mode_s;
    logic [OUT_W-1:0]   dec_s;
    logic               in_range_s;
    logic               at_last_s;

    assign mode_s    = mode_e'(mode);
    assign at_last_s = (index_r == LAST_IDX);

    onehot_decode #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_decode (
        .sel      (sel),
        .onehot   (dec_s),
        .in_range (in_range_s)
    );

    // Controller: state, scan counters and all output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            index_r <= '0;
            dwell_r <= '0;
            out_r   <= '0;
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (!en) begin
            state_r <= ST_IDLE;
            out_r   <= '0;
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (load) begin
            wrap_r <= 1'b0;
            if (mode_s == MODE_RSVD) begin
                state_r <= ST_IDLE;
                out_r   <= '0;
                busy_r  <= 1'b0;
                err_r   <= 1'b0;
            end else if (!in_range_s) begin
                // Never emit a partial or stale select for a bad index.
                state_r <= ST_IDLE;
                out_r   <= '0;
                busy_r  <= 1'b0;
                err_r   <= 1'b1;
            end else begin
                out_r <= dec_s;
                err_r <= 1'b0;
                case (mode_s)
                    MODE_LATCH: begin
                        state_r <= ST_HOLD;
                        busy_r  <= 1'b0;
                    end
                    MODE_PULSE: begin
                        state_r <= ST_PULSE;
                        busy_r  <= 1'b0;
                    end
                    MODE_SCAN: begin
                        state_r <= ST_SCAN;
                        index_r <= sel;
                        dwell_r <= hold;
                        busy_r  <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        out_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end else begin
            wrap_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    out_r  <= '0;
                    busy_r <= 1'b0;
                end
                ST_HOLD: begin
                    out_r  <= out_r;
                    busy_r <= 1'b0;
                end
                ST_PULSE: begin
                    state_r <= ST_IDLE;
                    out_r   <= '0;
                    busy_r  <= 1'b0;
                end
                ST_SCAN: begin
                    busy_r <= 1'b1;
                    if (dwell_r != '0) begin
                        dwell_r <= dwell_r - HOLD_W'(1);
                    end else begin
                        // out_r tracks onehot(index_r), so a rotate is the next select.
                        dwell_r <= hold;
                        out_r   <= {out_r[OUT_W-2:0], out_r[OUT_W-1]};
                        if (at_last_s) begin
                            index_r <= '0;
                            wrap_r  <= 1'b1;
                        end else begin
                            index_r <= index_r + SEL_W'(1);
                            wrap_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    out_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = out_r;
    assign busy = busy_r;
    assign wrap = wrap_r;
    assign err  = err_r;

endmodule
